// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl: IF-stage sequencer (PC, imem req/ack, skid, redirect). Rev 1.0
// Optional perf counters: define FETCH_PERF_CNT_EN.
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_ctrl #(
    parameter int                        MEM_ADDR_WIDTH = 32,
    parameter int                        REG_DATA_WIDTH = 32,
    parameter int                        STALL_WIDTH    = 2,
    parameter logic [STALL_WIDTH-1:0]    STALL_LOAD     = STALL_WIDTH'(1),
    parameter logic [MEM_ADDR_WIDTH-1:0] RESET_PC       = '0,
    parameter logic [MEM_ADDR_WIDTH-1:0] PC_STEP        = MEM_ADDR_WIDTH'(4)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STALL_WIDTH-1:0]    stall,
    input  logic                      branch_taken,
    input  logic [MEM_ADDR_WIDTH-1:0] branch_addr,
    output logic                      imem_req,
    output logic [MEM_ADDR_WIDTH-1:0] imem_addr,
    input  logic                      imem_ack,
    input  logic [REG_DATA_WIDTH-1:0] imem_rdata,
    output logic [MEM_ADDR_WIDTH-1:0] pc_out,
    output logic [REG_DATA_WIDTH-1:0] inst,
    output logic                      inst_valid,
    output logic [31:0]               fetch_cnt,
    output logic [31:0]               stall_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                      state;
    logic [MEM_ADDR_WIDTH-1:0]   pc;
    logic [MEM_ADDR_WIDTH-1:0]   redir_pc;
    logic [MEM_ADDR_WIDTH-1:0]   skid_pc;
    logic [REG_DATA_WIDTH-1:0]   skid_inst;
    logic [MEM_ADDR_WIDTH-1:0]   target;
    logic                        hold;

    assign hold      = (stall == STALL_LOAD);
    assign target    = branch_addr & ~MEM_ADDR_WIDTH'(3);
    // Request is a pure decode of registered state so ack/stall never reach it.
    assign imem_req  = (state == REQ) || (state == DRAIN);
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            redir_pc   <= '0;
            skid_pc    <= '0;
            skid_inst  <= '0;
            pc_out     <= '0;
            inst       <= '0;
            inst_valid <= 1'b0;
        end else if (branch_taken) begin
            inst       <= '0;
            inst_valid <= 1'b0;
            // An unacked request must complete before the target can be issued.
            if (imem_req && !imem_ack) begin
                redir_pc <= target;
                state    <= DRAIN;
            end else begin
                pc    <= target;
                state <= REQ;
            end
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                end
                REQ: begin
                    if (imem_ack) begin
                        pc <= pc + PC_STEP;
                        if (hold) begin
                            skid_inst <= imem_rdata;
                            skid_pc   <= pc;
                            state     <= HOLD;
                        end else begin
                            inst       <= imem_rdata;
                            pc_out     <= pc;
                            inst_valid <= 1'b1;
                        end
                    end else if (!hold) begin
                        inst_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!hold) begin
                        inst       <= skid_inst;
                        pc_out     <= skid_pc;
                        inst_valid <= 1'b1;
                        state      <= REQ;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        pc    <= redir_pc;
                        state <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic load_valid;
    logic stall_cycle;

    always_comb begin
        load_valid  = !branch_taken && !hold &&
                      (((state == REQ) && imem_ack) || (state == HOLD));
        stall_cycle = hold || (imem_req && !imem_ack);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (load_valid) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (stall_cycle) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`else
    assign fetch_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire
